// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and ramp state type for the pwm family
package pwm_pkg;

  localparam int unsigned MAIN_CLK_FREQUENCY = 25_000_000;
  localparam int unsigned USEC_IN_SEC        = 1_000_000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    RAMP   = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/ramp_step.sv
// rtl/ramp_step.sv - saturating single step of cur toward goal
module ramp_step (
  input  logic [15:0] cur,
  input  logic [15:0] goal,
  input  logic [15:0] step,
  output logic [15:0] next
);

  // Move by at most step; land exactly on goal when closer than one step
  always_comb begin
    next = goal;
    if (cur < goal) begin
      if ((goal - cur) > step) next = cur + step;
    end else begin
      if ((cur - goal) > step) next = cur - step;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - set-point controller slewing pwm duty and switching frequency
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned RAMP_CYCLES  = 25000,
  parameter int unsigned STEP_USEC    = 10,
  parameter int unsigned DEFAULT_FREQ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_freq,
  input  logic [15:0] cmd_duty_usec,
  input  logic        kill,
  output logic [15:0] freq,
  output logic [15:0] duty_cycle_usec,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(RAMP_CYCLES - 1);
  localparam logic [15:0]   STEP      = 16'(STEP_USEC);
  localparam logic [15:0]   FREQ_INIT = 16'(DEFAULT_FREQ);

  ramp_state_t   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [15:0]   tgt_freq, tgt_freq_next;
  logic [15:0]   tgt_duty, tgt_duty_next;
  logic [15:0]   freq_next, duty_next;
  logic          done_next, err_next;
  logic [15:0]   goal, stepped;
  logic [31:0]   product;
  logic          cmd_ok, tick;

  assign cmd_ready = (state == IDLE) && !kill;
  assign busy      = (state != IDLE);
  assign tick      = (cnt == CNT_LAST);
  assign product   = 32'(cmd_freq) * 32'(cmd_duty_usec);
  assign cmd_ok    = (cmd_freq != 16'd0) && (product <= USEC_IN_SEC);
  assign goal      = (state == DRAIN) ? 16'd0 : tgt_duty;

  ramp_step u_step (
    .cur  (duty_cycle_usec),
    .goal (goal),
    .step (STEP),
    .next (stepped)
  );

  // Next-state, datapath and pulse decode; kill overrides every other path
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    tgt_freq_next = tgt_freq;
    tgt_duty_next = tgt_duty;
    freq_next     = freq;
    duty_next     = duty_cycle_usec;
    done_next     = 1'b0;
    err_next      = 1'b0;
    if (kill) begin
      state_next = IDLE;
      duty_next  = 16'd0;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (!cmd_ok) begin
              err_next = 1'b1;
            end else begin
              tgt_freq_next = cmd_freq;
              tgt_duty_next = cmd_duty_usec;
              cnt_next      = '0;
              if (cmd_freq == freq) begin
                if (cmd_duty_usec == duty_cycle_usec) done_next = 1'b1;
                else state_next = RAMP;
              end else if (duty_cycle_usec == 16'd0) begin
                state_next = SWITCH;
              end else begin
                state_next = DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (tick) begin
            cnt_next  = '0;
            duty_next = stepped;
            if (stepped == 16'd0) state_next = SWITCH;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        SWITCH: begin
          freq_next = tgt_freq;
          cnt_next  = '0;
          if (tgt_duty == 16'd0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = RAMP;
          end
        end
        RAMP: begin
          if (tick) begin
            cnt_next  = '0;
            duty_next = stepped;
            if (stepped == tgt_duty) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      tgt_freq        <= FREQ_INIT;
      tgt_duty        <= 16'd0;
      freq            <= FREQ_INIT;
      duty_cycle_usec <= 16'd0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      tgt_freq        <= tgt_freq_next;
      tgt_duty        <= tgt_duty_next;
      freq            <= freq_next;
      duty_cycle_usec <= duty_next;
      done            <= done_next;
      err             <= err_next;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_freq;
  logic [15:0] cmd_duty_usec;
  logic        kill;
  logic [15:0] freq;
  logic [15:0] duty_cycle_usec;
  logic        busy;
  logic        done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  pwm_ramp_ctrl #(
    .RAMP_CYCLES (4),
    .STEP_USEC   (10),
    .DEFAULT_FREQ(1000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_freq        (cmd_freq),
    .cmd_duty_usec   (cmd_duty_usec),
    .kill            (kill),
    .freq            (freq),
    .duty_cycle_usec (duty_cycle_usec),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] f, input logic [15:0] d);
    cmd_freq      = f;
    cmd_duty_usec = d;
    cmd_valid     = 1'b1;
    step(1);
    cmd_valid     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; kill = 1'b0;
    cmd_freq = 16'd0; cmd_duty_usec = 16'd0;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_freq", freq, 1000);
    chk("rst_duty", duty_cycle_usec, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // ramp up 0 -> 35
    send(16'd1000, 16'd35);
    chk("up_busy", busy, 1);
    chk("up_ready", cmd_ready, 0);
    step(3); chk("up_pre", duty_cycle_usec, 0);
    step(1); chk("up_10", duty_cycle_usec, 10); chk("up_nodone", done, 0);
    step(4); chk("up_20", duty_cycle_usec, 20);
    step(4); chk("up_30", duty_cycle_usec, 30);
    step(4); chk("up_35", duty_cycle_usec, 35);
    chk("up_done", done, 1); chk("up_idle", busy, 0); chk("up_ready2", cmd_ready, 1);
    step(1); chk("up_done_clr", done, 0);

    // ramp down 35 -> 5
    send(16'd1000, 16'd5);
    step(4); chk("dn_25", duty_cycle_usec, 25);
    step(4); chk("dn_15", duty_cycle_usec, 15);
    step(4); chk("dn_5", duty_cycle_usec, 5); chk("dn_done", done, 1);
    step(1); chk("dn_done_clr", done, 0);

    // set (1000,20), then frequency change to (2000,15)
    send(16'd1000, 16'd20);
    step(4); chk("s20_15", duty_cycle_usec, 15);
    step(4); chk("s20_20", duty_cycle_usec, 20); chk("s20_done", done, 1);
    send(16'd2000, 16'd15);
    step(4); chk("fc_10", duty_cycle_usec, 10); chk("fc_f1", freq, 1000);
    step(4); chk("fc_0", duty_cycle_usec, 0); chk("fc_f2", freq, 1000);
    chk("fc_busy", busy, 1); chk("fc_nodone", done, 0);
    step(1); chk("fc_switch_f", freq, 2000); chk("fc_switch_d", duty_cycle_usec, 0);
    step(3); chk("fc_pre", duty_cycle_usec, 0);
    step(1); chk("fc_up10", duty_cycle_usec, 10);
    step(4); chk("fc_up15", duty_cycle_usec, 15); chk("fc_done", done, 1);
    chk("fc_idle", busy, 0);

    // rejects
    send(16'd2000, 16'd600);
    chk("rej_err", err, 1); chk("rej_freq", freq, 2000);
    chk("rej_duty", duty_cycle_usec, 15); chk("rej_busy", busy, 0); chk("rej_done", done, 0);
    step(1); chk("rej_err_clr", err, 0);
    send(16'd0, 16'd0);
    chk("rej0_err", err, 1);
    step(1); chk("rej0_err_clr", err, 0);

    // product exactly 1e6 is accepted; kill mid-ramp
    send(16'd2000, 16'd500);
    chk("lim_err", err, 0); chk("lim_busy", busy, 1);
    step(4); chk("lim_25", duty_cycle_usec, 25);
    kill = 1'b1;
    chk("kill_ready", cmd_ready, 0);
    step(1);
    chk("kill_duty", duty_cycle_usec, 0); chk("kill_busy", busy, 0);
    chk("kill_freq", freq, 2000); chk("kill_done", done, 0);
    cmd_freq = 16'd1000; cmd_duty_usec = 16'd50; cmd_valid = 1'b1;
    chk("kill_ready_idle", cmd_ready, 0);
    step(1);
    chk("killcmd_duty", duty_cycle_usec, 0); chk("killcmd_busy", busy, 0);
    chk("killcmd_freq", freq, 2000); chk("killcmd_err", err, 0); chk("killcmd_done", done, 0);
    kill = 1'b0; cmd_valid = 1'b0;
    step(1); chk("killcmd_drop", busy, 0);

    // no-op command
    send(16'd2000, 16'd0);
    chk("noop_done", done, 1); chk("noop_busy", busy, 0);
    step(1); chk("noop_done_clr", done, 0); chk("noop_busy2", busy, 0);

    // frequency change at zero duty goes straight through SWITCH
    send(16'd1000, 16'd0);
    chk("sw0_busy", busy, 1); chk("sw0_f_old", freq, 2000);
    step(1); chk("sw0_f_new", freq, 1000); chk("sw0_done", done, 1); chk("sw0_idle", busy, 0);

    // cmd_valid held through a ramp with changed data
    cmd_freq = 16'd1000; cmd_duty_usec = 16'd20; cmd_valid = 1'b1;
    step(1); chk("hold_busy", busy, 1);
    cmd_duty_usec = 16'd40;
    chk("hold_ready", cmd_ready, 0);
    step(4); chk("hold_10", duty_cycle_usec, 10);
    step(4); chk("hold_20", duty_cycle_usec, 20); chk("hold_done", done, 1);
    step(1); chk("hold_acc", busy, 1); chk("hold_done_clr", done, 0);
    cmd_valid = 1'b0;
    step(4); chk("hold_30", duty_cycle_usec, 30);
    step(4); chk("hold_40", duty_cycle_usec, 40); chk("hold_done2", done, 1);

    // asynchronous reset mid-ramp
    send(16'd2000, 16'd40);
    step(16); chk("ar_drained", duty_cycle_usec, 0); chk("ar_f_old", freq, 1000);
    step(1); chk("ar_f_new", freq, 2000);
    step(4); chk("ar_10", duty_cycle_usec, 10); chk("ar_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_duty", duty_cycle_usec, 0); chk("ar_freq", freq, 1000);
    chk("ar_busy0", busy, 0); chk("ar_ready", cmd_ready, 1);
    step(1);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
